// File: rtl/round_tracker_if.sv
// Judge-to-tracker result handshake.
// The judge drives valid/result; the tracker drives ready.
interface round_tracker_if;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;

  modport master (
    output result_valid,
    output result,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result,
    output result_ready
  );
endinterface

// File: rtl/round_tracker.sv
// Round/win/lose score keeper feeding the game-end checker.
// Each accepted result is followed by one CHECK cycle that samples fin/printwinner.
module round_tracker #(
  parameter int MAX_ROUND = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  round_tracker_if.slave   bus,
  input  logic             fin,
  input  logic [1:0]       printwinner,
  output logic [CNT_W-1:0] round,
  output logic [CNT_W-1:0] win,
  output logic [CNT_W-1:0] lose,
  output logic             busy,
  output logic             game_over,
  output logic [1:0]       final_winner,
  output logic             err_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_accept;
  logic             w_legal;
  logic             w_start;
  logic             w_end;
  logic [CNT_W-1:0] r_round;
  logic [CNT_W-1:0] r_win;
  logic [CNT_W-1:0] r_lose;
  logic [1:0]       r_fw;
  logic             r_err;

  assign w_accept = bus.result_valid & w_ready;
  assign w_legal  = (bus.result != 2'b00);
  assign w_start  = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_end    = fin | (r_round == CNT_W'(MAX_ROUND));

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_PLAY;
      S_PLAY:  if (w_accept && w_legal) w_next = S_CHECK;
      S_CHECK: w_next = w_end ? S_DONE : S_PLAY;
      S_DONE:  if (start) w_next = S_PLAY;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready   = 1'b0;
    busy      = 1'b0;
    game_over = 1'b0;
    unique case (r_state)
      S_IDLE:  ;
      S_PLAY:  begin w_ready = 1'b1; busy = 1'b1; end
      S_CHECK: busy = 1'b1;
      S_DONE:  game_over = 1'b1;
      default: ;
    endcase
  end

  // Illegal results are consumed but only flagged; counters stay put.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_round <= '0;
      r_win   <= '0;
      r_lose  <= '0;
      r_fw    <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_legal;
      if (w_start) begin
        r_round <= '0;
        r_win   <= '0;
        r_lose  <= '0;
        r_fw    <= 2'b00;
      end else if (w_accept && w_legal) begin
        r_round <= r_round + 1'b1;
        if (bus.result == 2'b10) r_win  <= r_win + 1'b1;
        if (bus.result == 2'b11) r_lose <= r_lose + 1'b1;
      end else if (r_state == S_CHECK && w_end) begin
        r_fw <= printwinner;
      end
    end
  end

  assign bus.result_ready = w_ready;
  assign round            = r_round;
  assign win              = r_win;
  assign lose             = r_lose;
  assign final_winner     = r_fw;
  assign err_pulse        = r_err;

endmodule

// File: tb/tb_round_tracker.sv
// Directed bench for round_tracker with a behavioural game-end checker.
// Each scenario task does its own inline comparisons.
module tb_round_tracker;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       fin;
  logic [1:0] printwinner;
  logic [3:0] round, win, lose;
  logic       busy, game_over, err_pulse;
  logic [1:0] final_winner;
  int         checks = 0;
  int         errors = 0;

  round_tracker_if rif ();

  round_tracker #(.MAX_ROUND(8), .CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bus          (rif),
    .fin          (fin),
    .printwinner  (printwinner),
    .round        (round),
    .win          (win),
    .lose         (lose),
    .busy         (busy),
    .game_over    (game_over),
    .final_winner (final_winner),
    .err_pulse    (err_pulse)
  );

  always #5 clk = ~clk;

  // Checker: game over once the leader can no longer be caught.
  function automatic logic [2:0] chk(input logic [3:0] r, w, l);
    int rem;
    logic f;
    logic [1:0] pw;
    rem = 8 - int'(r);
    f = (int'(w) > int'(l) + rem) || (int'(l) > int'(w) + rem);
    pw = (w > l) ? 2'b10 : (l > w) ? 2'b11 : 2'b01;
    return {f, pw};
  endfunction

  assign {fin, printwinner} = chk(round, win, lose);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] res);
    rif.result_valid = 1'b1;
    rif.result = res;
    tick();
    rif.result_valid = 1'b0;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({round, win, lose} !== 12'h000) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 000", {round, win, lose});
    end
    checks++;
    if ({rif.result_ready, busy, game_over, err_pulse, final_winner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {rif.result_ready, busy, game_over, err_pulse, final_winner});
    end
    reset_n = 1'b1;
    rif.result_valid = 1'b1;
    rif.result = 2'b10;
    tick();
    rif.result_valid = 1'b0;
    checks++;
    if (round !== 4'd0 || rif.result_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got round=%0d rdy=%b exp 0 0", round, rif.result_ready);
    end
  endtask

  task automatic test_p1_early_win();
    do_start();
    checks++;
    if (rif.result_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t2_play got rdy=%b busy=%b exp 1 1", rif.result_ready, busy);
    end
    for (int i = 0; i < 4; i++) send(2'b10);
    checks++;
    if (game_over !== 1'b0 || win !== 4'd4) begin
      errors++;
      $display("FAIL t2_four got go=%b win=%0d exp 0 4", game_over, win);
    end
    rif.result_valid = 1'b1;
    rif.result = 2'b10;
    tick();
    rif.result_valid = 1'b0;
    checks++;
    if (round !== 4'd5 || win !== 4'd5 || rif.result_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t2_check got r=%0d w=%0d rdy=%b busy=%b exp 5 5 0 1",
               round, win, rif.result_ready, busy);
    end
    tick();
    checks++;
    if (game_over !== 1'b1 || final_winner !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t2_done got go=%b fw=%b busy=%b exp 1 10 0",
               game_over, final_winner, busy);
    end
  endtask

  task automatic test_max_round();
    start = 1'b1;
    tick();
    checks++;
    if (round !== 4'd0 || win !== 4'd0 || final_winner !== 2'b00 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL t3_clear got r=%0d w=%0d fw=%b go=%b exp 0 0 00 0",
               round, win, final_winner, game_over);
    end
    tick();
    start = 1'b0;
    checks++;
    if (round !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_play got r=%0d busy=%b exp 0 1", round, busy);
    end
    for (int i = 0; i < 7; i++) send(i[0] ? 2'b11 : 2'b10);
    checks++;
    if (game_over !== 1'b0 || round !== 4'd7 || lose !== 4'd3) begin
      errors++;
      $display("FAIL t3_seven got go=%b r=%0d l=%0d exp 0 7 3", game_over, round, lose);
    end
    send(2'b11);
    checks++;
    if ({round, win, lose} !== 12'h844 || game_over !== 1'b1 || final_winner !== 2'b01) begin
      errors++;
      $display("FAIL t3_max got rwl=%h go=%b fw=%b exp 844 1 01",
               {round, win, lose}, game_over, final_winner);
    end
    tick();
    checks++;
    if (round !== 4'd8 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL t3_hold got r=%0d go=%b exp 8 1", round, game_over);
    end
  endtask

  task automatic test_illegal();
    do_start();
    rif.result_valid = 1'b1;
    rif.result = 2'b00;
    tick();
    rif.result_valid = 1'b0;
    checks++;
    if (err_pulse !== 1'b1 || round !== 4'd0 || rif.result_ready !== 1'b1) begin
      errors++;
      $display("FAIL t4_err got err=%b r=%0d rdy=%b exp 1 0 1",
               err_pulse, round, rif.result_ready);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b0 || {round, win, lose} !== 12'h000) begin
      errors++;
      $display("FAIL t4_after got err=%b rwl=%h exp 0 000", err_pulse, {round, win, lose});
    end
  endtask

  task automatic test_back_to_back();
    rif.result_valid = 1'b1;
    rif.result = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (round !== 4'(k) || rif.result_ready !== 1'b0) begin
        errors++;
        $display("FAIL t5_check%0d got r=%0d rdy=%b exp %0d 0", k, round, rif.result_ready, k);
      end
      tick();
      checks++;
      if (round !== 4'(k) || rif.result_ready !== 1'b1) begin
        errors++;
        $display("FAIL t5_play%0d got r=%0d rdy=%b exp %0d 1", k, round, rif.result_ready, k);
      end
    end
    rif.result_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b10);
    checks++;
    if ({round, win, lose} !== 12'h630 || game_over !== 1'b1 || final_winner !== 2'b10) begin
      errors++;
      $display("FAIL t5_end got rwl=%h go=%b fw=%b exp 630 1 10",
               {round, win, lose}, game_over, final_winner);
    end
  endtask

  task automatic test_restart_with_valid();
    start = 1'b1;
    rif.result_valid = 1'b1;
    rif.result = 2'b10;
    tick();
    start = 1'b0;
    rif.result_valid = 1'b0;
    checks++;
    if ({round, win, lose} !== 12'h000 || rif.result_ready !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL t6_restart got rwl=%h rdy=%b go=%b exp 000 1 0",
               {round, win, lose}, rif.result_ready, game_over);
    end
    tick();
    checks++;
    if (round !== 4'd0 || final_winner !== 2'b00) begin
      errors++;
      $display("FAIL t6_nocount got r=%0d fw=%b exp 0 00", round, final_winner);
    end
  endtask

  task automatic test_reset_mid_play();
    send(2'b10);
    send(2'b11);
    send(2'b01);
    checks++;
    if ({round, win, lose} !== 12'h311) begin
      errors++;
      $display("FAIL t1_pre got rwl=%h exp 311", {round, win, lose});
    end
    reset_n = 1'b0;
    rif.result_valid = 1'b1;
    rif.result = 2'b10;
    tick();
    rif.result_valid = 1'b0;
    checks++;
    if ({round, win, lose} !== 12'h000 || rif.result_ready !== 1'b0 ||
        final_winner !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_reset got rwl=%h rdy=%b fw=%b busy=%b exp 000 0 00 0",
               {round, win, lose}, rif.result_ready, final_winner, busy);
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    rif.result_valid = 1'b0;
    rif.result = 2'b00;
    test_reset();
    test_p1_early_win();
    test_max_round();
    test_illegal();
    test_back_to_back();
    test_restart_with_valid();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
